// File: rtl/hs_table_ctrl.sv
// High-score table update sequencer: reads the 3-entry table, ranks a new score,
// rewrites it shifted, and arbitrates display reads. Define HS_PERSIST_EN for a flush pulse.
module hs_table_ctrl (
  input  logic        clk,
  input  logic        Reset,
  input  logic        start,
  input  logic [31:0] new_score,
  input  logic        disp_req,
  input  logic [1:0]  disp_addr,
  output logic [31:0] disp_data,
  output logic        disp_valid,
  output logic        busy,
  output logic        done,
  output logic [1:0]  rank,
  output logic        ram_cs,
  output logic        ram_we,
  output logic [1:0]  ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  output logic        ram_done_wr
);
  typedef enum logic [2:0] {IDLE, RD0, RD1, RD2, CMP, WR, FLUSH, FIN} state_t;

  state_t      state, state_nx;
  logic [31:0] score;
  logic [31:0] old [3];
  logic [1:0]  wp;
  logic [1:0]  rank_c;
  logic        rd_disp;

  // Strictly greater: a tie leaves the existing entry ahead of the new one.
  always_comb begin
    if      (score > old[0]) rank_c = 2'd0;
    else if (score > old[1]) rank_c = 2'd1;
    else if (score > old[2]) rank_c = 2'd2;
    else                     rank_c = 2'd3;
  end

  always_comb begin
    state_nx    = state;
    ram_cs      = 1'b0;
    ram_we      = 1'b0;
    ram_addr    = 2'd0;
    ram_wdata   = 32'd0;
    ram_done_wr = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    rd_disp     = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nx = RD0;
        else if (disp_req) begin
          ram_cs   = 1'b1;
          ram_addr = disp_addr;
          rd_disp  = 1'b1;
        end
      end
      RD0: begin ram_cs = 1'b1; ram_addr = 2'd0; state_nx = RD1; end
      RD1: begin ram_cs = 1'b1; ram_addr = 2'd1; state_nx = RD2; end
      RD2: begin ram_cs = 1'b1; ram_addr = 2'd2; state_nx = CMP; end
      CMP: state_nx = (rank_c == 2'd3) ? FIN : WR;
      WR: begin
        ram_cs    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = wp;
        // wp > rank here whenever the old entry is used, so wp-1 never underflows.
        ram_wdata = (wp == rank) ? score : old[wp - 2'd1];
`ifdef HS_PERSIST_EN
        if (wp == 2'd2) state_nx = FLUSH;
`else
        if (wp == 2'd2) state_nx = FIN;
`endif
      end
`ifdef HS_PERSIST_EN
      FLUSH: begin ram_done_wr = 1'b1; state_nx = FIN; end
`endif
      FIN: begin done = 1'b1; state_nx = IDLE; end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state      <= IDLE;
      disp_data  <= 32'd0;
      disp_valid <= 1'b0;
      rank       <= 2'd3;
      score      <= 32'd0;
      wp         <= 2'd0;
      for (int i = 0; i < 3; i++) old[i] <= 32'd0;
    end else begin
      state      <= state_nx;
      disp_valid <= rd_disp;
      if (rd_disp) disp_data <= ram_rdata;
      case (state)
        IDLE: if (start) score <= new_score;
        RD0:  old[0] <= ram_rdata;
        RD1:  old[1] <= ram_rdata;
        RD2:  old[2] <= ram_rdata;
        CMP: begin
          rank <= rank_c;
          wp   <= rank_c;
        end
        WR:   wp <= wp + 2'd1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_hs_table_ctrl.sv
// Directed bench for hs_table_ctrl with a combinational-read RAM model preloaded to {500,300,100}.
module tb_hs_table_ctrl;
`ifdef HS_PERSIST_EN
  localparam int FL = 1;
`else
  localparam int FL = 0;
`endif

  logic        clk = 1'b0, Reset = 1'b1, start = 1'b0, disp_req = 1'b0;
  logic [31:0] new_score = 32'd0;
  logic [1:0]  disp_addr = 2'd0;
  logic [31:0] disp_data, ram_wdata, ram_rdata;
  logic        disp_valid, busy, done, ram_cs, ram_we, ram_done_wr;
  logic [1:0]  rank, ram_addr;
  logic        load = 1'b0;
  logic [31:0] mem [3];
  int          total = 0, passed = 0;

  always #5 clk = ~clk;

  hs_table_ctrl dut (
    .clk(clk), .Reset(Reset), .start(start), .new_score(new_score),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_data(disp_data),
    .disp_valid(disp_valid), .busy(busy), .done(done), .rank(rank),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_done_wr(ram_done_wr)
  );

  assign ram_rdata = (ram_addr < 2'd3) ? mem[ram_addr] : 32'd0;
  always @(posedge clk) begin
    if (load) begin
      mem[0] <= 32'd500; mem[1] <= 32'd300; mem[2] <= 32'd100;
    end else if (ram_cs && ram_we && ram_addr < 2'd3) mem[ram_addr] <= ram_wdata;
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic preload();
    load = 1'b1; step(); load = 1'b0;
  endtask

  // Pulse start in cycle 0 and watch until done; returns with cycle done+1 current.
  task automatic run_update(input logic [31:0] sc, output int dcyc, output int nwr,
                            output int nfl, output int flcyc, output int ndv);
    dcyc = -1; nwr = 0; nfl = 0; flcyc = -1; ndv = 0;
    start = 1'b1; new_score = sc;
    step();
    start = 1'b0;
    for (int c = 1; c <= 20 && dcyc < 0; c++) begin
      if (ram_cs && ram_we) nwr++;
      if (ram_done_wr) begin nfl++; flcyc = c; end
      if (disp_valid) ndv++;
      if (done) dcyc = c;
      step();
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; step(); step(); Reset = 1'b0;
    total++;
    if ({busy, done, disp_valid, ram_cs, ram_we, ram_done_wr} !== 6'b0)
      $display("FAIL reset_ctrl got=%b exp=000000", {busy, done, disp_valid, ram_cs, ram_we, ram_done_wr});
    else passed++;
    total++;
    if (rank !== 2'd3 || disp_data !== 32'd0)
      $display("FAIL reset_rank_data rank=%0d data=%0d exp rank=3 data=0", rank, disp_data);
    else passed++;
  endtask

  task automatic test_insert_mid();
    int d, w, f, fc, v;
    preload();
    run_update(32'd400, d, w, f, fc, v);
    total++;
    if (rank !== 2'd1) $display("FAIL mid_rank got=%0d exp=1", rank); else passed++;
    total++;
    if (w !== 2) $display("FAIL mid_writes got=%0d exp=2", w); else passed++;
    total++;
    if (d !== 7 + FL) $display("FAIL mid_done_cycle got=%0d exp=%0d", d, 7 + FL); else passed++;
    total++;
    if (f !== FL || (FL == 1 && fc !== 7))
      $display("FAIL mid_flush count=%0d cycle=%0d exp count=%0d cycle=7", f, fc, FL);
    else passed++;
    total++;
    if (mem[0] !== 32'd500 || mem[1] !== 32'd400 || mem[2] !== 32'd300)
      $display("FAIL mid_ram got={%0d,%0d,%0d} exp={500,400,300}", mem[0], mem[1], mem[2]);
    else passed++;
  endtask

  task automatic test_not_placed();
    int d, w, f, fc, v;
    preload();
    run_update(32'd50, d, w, f, fc, v);
    total++;
    if (rank !== 2'd3) $display("FAIL np_rank got=%0d exp=3", rank); else passed++;
    total++;
    if (w !== 0 || f !== 0) $display("FAIL np_writes wr=%0d flush=%0d exp 0/0", w, f); else passed++;
    total++;
    if (d !== 5) $display("FAIL np_done_cycle got=%0d exp=5", d); else passed++;
    total++;
    if (mem[0] !== 32'd500 || mem[1] !== 32'd300 || mem[2] !== 32'd100)
      $display("FAIL np_ram got={%0d,%0d,%0d} exp={500,300,100}", mem[0], mem[1], mem[2]);
    else passed++;
  endtask

  task automatic test_tie_top();
    int d, w, f, fc, v;
    preload();
    run_update(32'd100, d, w, f, fc, v);
    total++;
    if (rank !== 2'd3 || w !== 0) $display("FAIL tie_rank rank=%0d wr=%0d exp 3/0", rank, w); else passed++;
    run_update(32'd600, d, w, f, fc, v);
    total++;
    if (rank !== 2'd0 || w !== 3) $display("FAIL top_rank rank=%0d wr=%0d exp 0/3", rank, w); else passed++;
    total++;
    if (d !== 8 + FL) $display("FAIL top_done_cycle got=%0d exp=%0d", d, 8 + FL); else passed++;
    total++;
    if (mem[0] !== 32'd600 || mem[1] !== 32'd500 || mem[2] !== 32'd300)
      $display("FAIL top_ram got={%0d,%0d,%0d} exp={600,500,300}", mem[0], mem[1], mem[2]);
    else passed++;
  endtask

  task automatic test_display();
    preload();
    disp_req = 1'b1; disp_addr = 2'd2;
    total++;
    if (disp_valid !== 1'b0) $display("FAIL disp_early got=%b exp=0", disp_valid); else passed++;
    step();
    disp_req = 1'b0;
    total++;
    if (disp_valid !== 1'b1 || disp_data !== 32'd100)
      $display("FAIL disp_read valid=%b data=%0d exp 1/100", disp_valid, disp_data);
    else passed++;
    disp_addr = 2'd0;
    step();
    total++;
    if (disp_valid !== 1'b0) $display("FAIL disp_pulse got=%b exp=0", disp_valid); else passed++;
  endtask

  task automatic test_arbitration();
    int d, w, f, fc, v;
    preload();
    disp_req = 1'b1; disp_addr = 2'd2;
    run_update(32'd400, d, w, f, fc, v);
    total++;
    if (v !== 0 || d !== 7 + FL) $display("FAIL arb_update dv=%0d done=%0d exp 0/%0d", v, d, 7 + FL); else passed++;
    total++;
    if (disp_valid !== 1'b0) $display("FAIL arb_idle_cycle valid=%b exp=0", disp_valid); else passed++;
    step();
    disp_req = 1'b0;
    total++;
    if (disp_valid !== 1'b1 || disp_data !== 32'd300)
      $display("FAIL arb_read valid=%b data=%0d exp 1/300", disp_valid, disp_data);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int w = 0, f = 0;
    preload();
    start = 1'b1; new_score = 32'd600;
    step();
    start = 1'b0;
    for (int c = 1; c < 5; c++) step();
    total++;
    if (ram_we !== 1'b1 || busy !== 1'b1) $display("FAIL rst_in_wr we=%b busy=%b exp 1/1", ram_we, busy); else passed++;
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    total++;
    if (busy !== 1'b0 || rank !== 2'd3) $display("FAIL rst_state busy=%b rank=%0d exp 0/3", busy, rank); else passed++;
    for (int c = 0; c < 10; c++) begin
      if (ram_cs && ram_we) w++;
      if (ram_done_wr) f++;
      step();
    end
    total++;
    if (w !== 0 || f !== 0) $display("FAIL rst_after wr=%0d flush=%0d exp 0/0", w, f); else passed++;
    total++;
    if (mem[0] !== 32'd600 || mem[1] !== 32'd300 || mem[2] !== 32'd100)
      $display("FAIL rst_ram got={%0d,%0d,%0d} exp={600,300,100}", mem[0], mem[1], mem[2]);
    else passed++;
  endtask

  initial begin
    #1;
    test_reset();
    test_insert_mid();
    test_not_placed();
    test_tie_top();
    test_display();
    test_arbitration();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/hs_table_ctrl.md
# hs_table_ctrl

Sequencing controller for the three-entry high-score RAM (32-bit words, addresses 0–2, entry 0 highest). On a game-over pulse it:
- reads the table,
- finds where the final score ranks,
- rewrites the table with the score inserted and lower entries shifted down,
- optionally requests a persistence flush.

Between updates it shares the RAM with the score-display logic through a simple read-request port. It sits between the game FSM, the score display, and the score RAM.

## Interface
Parameters:
- none

Ports:
- clk  in  1  system clock; all logic rising-edge.
- Reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle game-over pulse; sampled only in IDLE.
- new_score  in  32  final score, unsigned; sampled with start.
- disp_req  in  1  display read request; held high until disp_valid.
- disp_addr  in  2  display read address (0–2).
- disp_data  out  32  registered read data.
- disp_valid  out  1  one-cycle pulse: disp_data valid.
- busy  out  1  high from RD0 through FIN.
- done  out  1  one-cycle pulse in FIN.
- rank  out  2  placement of last score: 0–2, or 3 = not placed; held until next start.
- ram_cs  out  1  RAM chip select.
- ram_we  out  1  RAM write enable.
- ram_addr  out  2  RAM address.
- ram_wdata  out  32  RAM write data.
- ram_rdata  in  32  RAM read data; combinational, valid in the same cycle as cs && !we.
- ram_done_wr  out  1  persistence flush request to the RAM.

## Operation
States: IDLE, RD0, RD1, RD2, CMP, WR, FLUSH, FIN.

**IDLE**
- If start = 1, latch new_score and go to RD0. start has priority over disp_req.
- Otherwise, if disp_req = 1:
  - drive ram_cs = 1, ram_we = 0, ram_addr = disp_addr;
  - register ram_rdata into disp_data;
  - pulse disp_valid on the next cycle.
- A request presented while busy waits; the requester holds it.
- Back-to-back display reads are allowed. One read completes per 2 cycles, because the request must drop for the cycle after disp_valid.

**RD0, RD1, RD2**
- Read addresses 0, 1, 2 in turn.
- Capture each into internal old[0..2] at the end of the state.

**CMP**
- rank = lowest i with new_score > old[i]. The comparison is unsigned and strictly greater, so ties keep the older entry.
- If no such i: rank = 3, go to FIN with no writes.
- Otherwise load the write pointer wp = rank and go to WR.

**WR**
- One write per cycle at ram_addr = wp, with ram_cs = ram_we = 1.
- Write data:
  - if wp == rank: ram_wdata = new_score;
  - else: ram_wdata = old[wp-1].
- wp increments each cycle. After the write at address 2, go to FLUSH.
- Entries below rank are never rewritten.
- The old entry at address 2 is discarded when rank ≤ 2.

**FLUSH**
- ram_done_wr = 1 for one cycle (see Configuration), ram_cs = 0, then go to FIN.

**FIN**
- done = 1 for one cycle, then go to IDLE.

**RAM port outside the cases above**
- ram_cs = ram_we = 0; ram_addr, ram_wdata = 0.

**Reset**
- Any state goes to IDLE.
- Outputs: busy, done, disp_valid, ram_cs, ram_we, ram_done_wr = 0; disp_data = 0; rank = 3; ram_addr = 0; ram_wdata = 0.
- Reset during WR leaves the RAM partially updated. No further writes are issued, and no flush is issued.

## Timing
Start is accepted at cycle 0 edge; RD0 is cycle 1.
- Placed case: 3 RD + 1 CMP + (3 − rank) WR + 1 FLUSH + 1 FIN cycles.
  - rank 0: done in cycle 9.
  - rank 2: done in cycle 7.
- Not-placed case: done in cycle 5.
- Display read: disp_req seen in IDLE in cycle n gives disp_valid in cycle n+1.
- A start pulse outside IDLE is ignored.
- start and disp_req together in IDLE: the update runs first, and the display read is served in the first IDLE cycle after FIN.

## Configuration
HS_PERSIST_EN:
- **Defined:** the FLUSH state exists and pulses ram_done_wr for one cycle after the final write. Placed-case latency is as above.
- **Undefined:**
  - ram_done_wr is tied 0;
  - FLUSH is removed and WR goes directly to FIN;
  - placed-case latency is one cycle shorter (rank 0: done in cycle 8).

## Test plan
All scenarios start with the RAM preloaded with {500, 300, 100} and HS_PERSIST_EN defined unless stated.
- **Insert mid-table:** start with new_score = 400.
  - Writes: addr1 = 400, addr2 = 300.
  - rank = 1; RAM ends {500, 400, 300}.
  - ram_done_wr pulses in cycle 7; done in cycle 8.
- **Not placed:** new_score = 50.
  - rank = 3; no ram_we; no ram_done_wr; done in cycle 5; RAM unchanged.
- **Tie and top insert:**
  - new_score = 100: rank = 3.
  - new_score = 600: rank = 0; RAM ends {600, 500, 300}; done in cycle 9.
- **Display arbitration:**
  - disp_req with addr 2 in IDLE: disp_valid next cycle with disp_data = 100.
  - disp_req asserted together with start (new_score = 400): disp_valid arrives the cycle after the first post-FIN IDLE cycle, with data 300.
- **Reset mid-update:** new_score = 600; assert Reset in the first WR cycle.
  - Next cycle: IDLE, busy = 0, rank = 3.
  - No further writes; ram_done_wr never asserted.
- **Macro off:** HS_PERSIST_EN undefined, new_score = 400.
  - ram_done_wr stays 0; done in cycle 7.
